// File: rtl/latch_write_arbiter_pkg.sv
// Shared state encoding and default parameters for the latch write arbiter.
package latch_write_arbiter_pkg;

  localparam int DEF_NREQ     = 4;
  localparam int DEF_W        = 8;
  localparam int DEF_OPEN_CYC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETUP,
    ST_OPEN,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/latch_write_arbiter_if.sv
// Requester/latch-bank bundle; master drives requests, slave is the arbiter.
interface latch_write_arbiter_if
  import latch_write_arbiter_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int W    = DEF_W
);

  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_data;
  logic              clr_req;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   done;
  logic              clr_done;
  logic [W-1:0]      lat_data;
  logic              lat_en;
  logic              lat_clr;
  logic              busy;

  modport master (
    output req, req_data, clr_req,
    input  grant, done, clr_done, lat_data, lat_en, lat_clr, busy
  );

  modport slave (
    input  req, req_data, clr_req,
    output grant, done, clr_done, lat_data, lat_en, lat_clr, busy
  );

endinterface

// File: rtl/latch_write_arbiter_rr_pick.sv
// Combinational round-robin select: first set request at or after ptr_i, wrapping.
module latch_write_arbiter_rr_pick
  import latch_write_arbiter_pkg::*;
#(
  parameter int  NREQ = DEF_NREQ,
  localparam int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   idx_o,
  output logic            any_o
);

  logic [PW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = PW'((int'(ptr_i) + i) % NREQ);
      if (!any_o && req_i[cand]) begin
        any_o = 1'b1;
        idx_o = cand;
      end
    end
    gnt_o[idx_o] = any_o;
  end

endmodule

// File: rtl/latch_write_arbiter.sv
// Round-robin arbiter sharing one latch bank; each write runs setup, enable window, hold
// so D is stable whenever lat_en is high. Clear requests win over writes at IDLE.
module latch_write_arbiter
  import latch_write_arbiter_pkg::*;
#(
  parameter int NREQ     = DEF_NREQ,
  parameter int W        = DEF_W,
  parameter int OPEN_CYC = DEF_OPEN_CYC
) (
  input  logic                 clk,
  input  logic                 reset,
  latch_write_arbiter_if.slave bus
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = $clog2(OPEN_CYC + 1);

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            clr_done_q, clr_done_d;
  logic [W-1:0]    lat_data_q, lat_data_d;
  logic            lat_en_q, lat_en_d;
  logic            lat_clr_q, lat_clr_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] pick_gnt;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  latch_write_arbiter_rr_pick #(.NREQ(NREQ)) u_pick (
    .req_i (bus.req),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    cnt_d      = cnt_q;
    grant_d    = grant_q;
    done_d     = '0;
    clr_done_d = 1'b0;
    lat_data_d = lat_data_q;
    lat_en_d   = lat_en_q;
    lat_clr_d  = lat_clr_q;
    busy_d     = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.clr_req) begin
          state_d   = ST_CLEAR;
          lat_clr_d = 1'b1;
          busy_d    = 1'b1;
        end else if (pick_any) begin
          state_d    = ST_SETUP;
          grant_d    = pick_gnt;
          gidx_d     = pick_idx;
          lat_data_d = bus.req_data[int'(pick_idx)*W +: W];
          busy_d     = 1'b1;
        end
      end
      ST_CLEAR: begin
        state_d    = ST_IDLE;
        lat_clr_d  = 1'b0;
        clr_done_d = 1'b1;
        busy_d     = 1'b0;
      end
      ST_SETUP: begin
        state_d  = ST_OPEN;
        lat_en_d = 1'b1;
        cnt_d    = CW'(OPEN_CYC - 1);
      end
      ST_OPEN: begin
        // Enable stays high for OPEN_CYC cycles: the counter value plus this cycle.
        if (cnt_q == '0) begin
          state_d  = ST_HOLD;
          lat_en_d = 1'b0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_HOLD: begin
        state_d  = ST_IDLE;
        done_d   = grant_q;
        grant_d  = '0;
        busy_d   = 1'b0;
        rr_ptr_d = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + PW'(1);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      done_q     <= '0;
      clr_done_q <= 1'b0;
      lat_data_q <= '0;
      lat_en_q   <= 1'b0;
      lat_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      cnt_q      <= cnt_d;
      grant_q    <= grant_d;
      done_q     <= done_d;
      clr_done_q <= clr_done_d;
      lat_data_q <= lat_data_d;
      lat_en_q   <= lat_en_d;
      lat_clr_q  <= lat_clr_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.clr_done = clr_done_q;
  assign bus.lat_data = lat_data_q;
  assign bus.lat_en   = lat_en_q;
  assign bus.lat_clr  = lat_clr_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_latch_write_arbiter.sv
// Directed bench for latch_write_arbiter with NREQ=4, W=8, OPEN_CYC=2.
module tb_latch_write_arbiter;

  localparam int NREQ     = 4;
  localparam int W        = 8;
  localparam int OPEN_CYC = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  latch_write_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();

  latch_write_arbiter #(.NREQ(NREQ), .W(W), .OPEN_CYC(OPEN_CYC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int i, input logic [W-1:0] v);
    bus.req_data[i*W +: W] = v;
  endtask

  task automatic do_reset;
    reset        = 1'b0;
    bus.req      = '0;
    bus.clr_req  = 1'b0;
    bus.req_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick;
  endtask

  // Invariants sampled on the falling edge throughout the run.
  logic         prev_en = 1'b0;
  logic [W-1:0] prev_data = '0;
  always @(negedge clk) begin
    if (reset) begin
      n_tests++;
      if (!$onehot0(bus.grant)) begin
        n_fail++;
        $display("FAIL inv_grant_onehot: grant=%b not one-hot or zero", bus.grant);
      end
      n_tests++;
      if (bus.lat_en && prev_en && (bus.lat_data !== prev_data)) begin
        n_fail++;
        $display("FAIL inv_data_stable: lat_data=%h changed from %h while lat_en high", bus.lat_data, prev_data);
      end
      n_tests++;
      if (bus.lat_en && (bus.lat_clr || bus.grant == '0 || !bus.busy)) begin
        n_fail++;
        $display("FAIL inv_en_context: lat_en=1 with lat_clr=%b grant=%b busy=%b, required lat_clr=0 grant!=0 busy=1",
                 bus.lat_clr, bus.grant, bus.busy);
      end
      prev_en   = bus.lat_en;
      prev_data = bus.lat_data;
    end else begin
      prev_en = 1'b0;
      n_tests++;
      if (bus.done !== '0 || bus.lat_en !== 1'b0) begin
        n_fail++;
        $display("FAIL inv_reset_quiet: done=%b lat_en=%b during reset, required 0", bus.done, bus.lat_en);
      end
    end
  end

  task automatic test_reset;
    bus.req      = '0;
    bus.clr_req  = 1'b0;
    bus.req_data = '0;
    #2 reset = 1'b0;
    #10;
    n_tests++;
    if ({bus.grant, bus.done, bus.clr_done, bus.lat_data, bus.lat_en, bus.lat_clr, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b done=%b clr_done=%b lat_data=%h lat_en=%b lat_clr=%b busy=%b, required all 0",
               bus.grant, bus.done, bus.clr_done, bus.lat_data, bus.lat_en, bus.lat_clr, bus.busy);
    end
    @(negedge clk);
    reset = 1'b1;
    tick;
    tick;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.grant !== '0) begin
      n_fail++;
      $display("FAIL reset_idle: busy=%b grant=%b, required 0/0", bus.busy, bus.grant);
    end
  endtask

  task automatic test_single_write;
    set_slice(0, 8'hA5);
    bus.req = 4'b0001;
    tick;
    n_tests++;
    if (bus.grant !== 4'b0001 || bus.lat_data !== 8'hA5 || bus.lat_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: grant=%b lat_data=%h lat_en=%b busy=%b, required 0001/a5/0/1",
               bus.grant, bus.lat_data, bus.lat_en, bus.busy);
    end
    tick;
    n_tests++;
    if (bus.lat_en !== 1'b1) begin
      n_fail++;
      $display("FAIL single_open1: lat_en=%b, required 1", bus.lat_en);
    end
    tick;
    n_tests++;
    if (bus.lat_en !== 1'b1 || bus.lat_data !== 8'hA5) begin
      n_fail++;
      $display("FAIL single_open2: lat_en=%b lat_data=%h, required 1/a5", bus.lat_en, bus.lat_data);
    end
    tick;
    n_tests++;
    if (bus.lat_en !== 1'b0 || bus.grant !== 4'b0001 || bus.done !== '0) begin
      n_fail++;
      $display("FAIL single_hold: lat_en=%b grant=%b done=%b, required 0/0001/0000", bus.lat_en, bus.grant, bus.done);
    end
    tick;
    n_tests++;
    if (bus.done !== 4'b0001 || bus.grant !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_done: done=%b grant=%b busy=%b, required 0001/0000/0", bus.done, bus.grant, bus.busy);
    end
    bus.req = '0;
    tick;
    n_tests++;
    if (bus.done !== '0 || bus.lat_data !== 8'hA5 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_after: done=%b lat_data=%h busy=%b, required 0000/a5/0", bus.done, bus.lat_data, bus.busy);
    end
  endtask

  task automatic test_round_robin;
    logic [NREQ-1:0] exp_g;
    logic [W-1:0]    exp_d;
    do_reset;
    set_slice(0, 8'h11);
    set_slice(1, 8'h22);
    set_slice(2, 8'h33);
    set_slice(3, 8'h44);
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      exp_d = 8'(8'h11 * ((k % 4) + 1));
      tick;
      n_tests++;
      if (bus.grant !== exp_g || bus.lat_data !== exp_d) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: grant=%b lat_data=%h, required %b/%h", k, bus.grant, bus.lat_data, exp_g, exp_d);
      end
      tick;
      n_tests++;
      if (bus.lat_en !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_open[%0d]: lat_en=%b, required 1", k, bus.lat_en);
      end
      tick;
      tick;
      tick;
      n_tests++;
      if (bus.done !== exp_g || bus.grant !== '0) begin
        n_fail++;
        $display("FAIL rr_done[%0d]: done=%b grant=%b, required %b/0000", k, bus.done, bus.grant, exp_g);
      end
      if (k == 4) bus.req = '0;
    end
    tick;
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== '0) begin
      n_fail++;
      $display("FAIL rr_idle: busy=%b done=%b, required 0/0000", bus.busy, bus.done);
    end
  endtask

  task automatic test_clear;
    do_reset;
    set_slice(2, 8'hC3);
    bus.req     = 4'b0100;
    bus.clr_req = 1'b1;
    tick;
    n_tests++;
    if (bus.lat_clr !== 1'b1 || bus.grant !== '0 || bus.lat_en !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_active: lat_clr=%b grant=%b lat_en=%b busy=%b, required 1/0000/0/1",
               bus.lat_clr, bus.grant, bus.lat_en, bus.busy);
    end
    tick;
    n_tests++;
    if (bus.lat_clr !== 1'b0 || bus.clr_done !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_done: lat_clr=%b clr_done=%b busy=%b, required 0/1/0", bus.lat_clr, bus.clr_done, bus.busy);
    end
    bus.clr_req = 1'b0;
    tick;
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.lat_data !== 8'hC3 || bus.clr_done !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_then_write: grant=%b lat_data=%h clr_done=%b, required 0100/c3/0",
               bus.grant, bus.lat_data, bus.clr_done);
    end
    repeat (4) tick;
    n_tests++;
    if (bus.done !== 4'b0100) begin
      n_fail++;
      $display("FAIL clr_write_done: done=%b, required 0100", bus.done);
    end
    bus.req = '0;
    tick;
    // Pointer now sits at 3; a clear must leave it there.
    bus.clr_req = 1'b1;
    tick;
    tick;
    n_tests++;
    if (bus.clr_done !== 1'b1) begin
      n_fail++;
      $display("FAIL clr2_done: clr_done=%b, required 1", bus.clr_done);
    end
    bus.clr_req = 1'b0;
    set_slice(0, 8'h01);
    set_slice(3, 8'h83);
    bus.req = 4'b1001;
    tick;
    n_tests++;
    if (bus.grant !== 4'b1000 || bus.lat_data !== 8'h83) begin
      n_fail++;
      $display("FAIL clr_keeps_ptr: grant=%b lat_data=%h, required 1000/83", bus.grant, bus.lat_data);
    end
    repeat (4) tick;
    n_tests++;
    if (bus.done !== 4'b1000) begin
      n_fail++;
      $display("FAIL clr2_write_done: done=%b, required 1000", bus.done);
    end
    bus.req = '0;
    tick;
  endtask

  task automatic test_reset_mid_open;
    do_reset;
    set_slice(2, 8'h5A);
    bus.req = 4'b0100;
    tick;
    tick;
    n_tests++;
    if (bus.lat_en !== 1'b1 || bus.grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_pre_open: lat_en=%b grant=%b, required 1/0100", bus.lat_en, bus.grant);
    end
    #3 reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.grant, bus.done, bus.clr_done, bus.lat_data, bus.lat_en, bus.lat_clr, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL rst_async: grant=%b done=%b lat_data=%h lat_en=%b busy=%b, required all 0",
               bus.grant, bus.done, bus.lat_data, bus.lat_en, bus.busy);
    end
    set_slice(2, 8'h77);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick;
    n_tests++;
    if (bus.grant !== 4'b0100 || bus.lat_data !== 8'h77) begin
      n_fail++;
      $display("FAIL rst_regrant: grant=%b lat_data=%h, required 0100/77", bus.grant, bus.lat_data);
    end
    repeat (4) tick;
    n_tests++;
    if (bus.done !== 4'b0100) begin
      n_fail++;
      $display("FAIL rst_regrant_done: done=%b, required 0100", bus.done);
    end
    bus.req = '0;
    tick;
  endtask

  task automatic test_req_drop;
    set_slice(1, 8'h3C);
    bus.req = 4'b0010;
    tick;
    n_tests++;
    if (bus.grant !== 4'b0010 || bus.lat_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL drop_grant: grant=%b lat_data=%h, required 0010/3c", bus.grant, bus.lat_data);
    end
    bus.req = '0;
    set_slice(1, 8'hFF);
    tick;
    n_tests++;
    if (bus.lat_en !== 1'b1 || bus.lat_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL drop_open: lat_en=%b lat_data=%h, required 1/3c", bus.lat_en, bus.lat_data);
    end
    tick;
    tick;
    tick;
    n_tests++;
    if (bus.done !== 4'b0010 || bus.lat_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL drop_done: done=%b lat_data=%h, required 0010/3c", bus.done, bus.lat_data);
    end
    tick;
    n_tests++;
    if (bus.done !== '0 || bus.grant !== '0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drop_idle: done=%b grant=%b busy=%b, required 0000/0000/0", bus.done, bus.grant, bus.busy);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_clear;
    test_reset_mid_open;
    test_req_drop;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
